decodificador_servo_3: RTL and testbench
========================================

DECODIFICADOR_SERVO_3 -- requirements
Module: decodificador_servo_3

Interface
REQ-001 The block SHALL expose parameter CICLOS_BASE, default 50_000, nominal high-width in clock cycles for posicao 000 (1.0 ms at 50 MHz).
REQ-002 The block SHALL expose parameter CICLOS_PASSO, default 6_250, width increment per position step (0.125 ms).
REQ-003 The block SHALL expose parameter CICLOS_TIMEOUT, default 1_250_000, cycles without a rising edge before loss of signal (25 ms).
REQ-004 The block SHALL expose parameter CICLOS_MAX_ALTO, default 150_000, high-time limit treated as a stuck line (3 ms).
REQ-005 The block SHALL have port clock, input, 1 bit, 50 MHz system clock; one clock, all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, synchronous and active-high.
REQ-007 The block SHALL have port pwm, input, 1 bit, asynchronous servo PWM line (period 20 ms).
REQ-008 The block SHALL have port posicao, output, 3 bits, last validly decoded position.
REQ-009 The block SHALL have port valido, output, 1 bit, one-cycle pulse per validly decoded pulse.
REQ-010 The block SHALL have port erro, output, 1 bit, sticky flag: last pulse out of range or stuck high.
REQ-011 The block SHALL have port sem_sinal, output, 1 bit, no rising edge within CICLOS_TIMEOUT.
REQ-012 The block SHALL have port db_estado, output, 2 bits, current FSM state encoding for debug.

Function
REQ-013 pwm SHALL pass through a 2-flop synchronizer; edge detection SHALL compare synchronized sample with its previous value.
REQ-014 FSM states SHALL be ESPERA_BAIXO (00), ESPERA_SUBIDA (01), MEDE_ALTO (10), DECODIFICA (11).
REQ-015 ESPERA_BAIXO -> ESPERA_SUBIDA when synchronized pwm=0; used after reset and after stuck-high, so a partial pulse is never measured.
REQ-016 ESPERA_SUBIDA -> MEDE_ALTO on rising edge; the width counter SHALL load 1 in that cycle.
REQ-017 In MEDE_ALTO the width counter SHALL increment each cycle synchronized pwm=1; on falling edge -> DECODIFICA.
REQ-018 If the width counter reaches CICLOS_MAX_ALTO in MEDE_ALTO: erro SHALL be set, posicao held, and the FSM SHALL go to ESPERA_BAIXO.
REQ-019 DECODIFICA SHALL last exactly one cycle, then -> ESPERA_SUBIDA; valido or erro SHALL update at its end.
REQ-020 Let L = width count and T_j = CICLOS_BASE + j*CICLOS_PASSO - CICLOS_PASSO/2; L is valid iff T_0 <= L < T_8 (46_875 <= L < 96_875 by default).
REQ-021 For valid L, posicao SHALL equal the count of j in 1..7 with L >= T_j, using comparators only and no divider; a value exactly on T_j rounds up.
REQ-022 For valid L: posicao updated, valido=1 for one cycle, erro cleared, sem_sinal cleared.
REQ-023 For invalid L: posicao held, valido stays 0, erro set.
REQ-024 Latency SHALL be exactly 4 rising clock edges from the first edge sampling pwm=0 to the edge that raises valido.
REQ-025 A period counter SHALL reset on every synchronized rising edge and saturate at CICLOS_TIMEOUT; reaching it SHALL set sem_sinal; the FSM is not altered.
REQ-026 A rising edge and a period-counter timeout in the same cycle SHALL favour the edge: counter reset, sem_sinal unchanged.
REQ-027 The width counter SHALL be 18 bits and the period counter 21 bits; neither SHALL wrap.

Reset
REQ-028 On reset=1 the block SHALL set: posicao=000, valido=0, erro=0, sem_sinal=0, db_estado=00 (ESPERA_BAIXO), both counters=0, synchronizer flops=0.
REQ-029 Reset asserted mid-pulse SHALL discard the measurement; the next decode SHALL come only from a complete subsequent pulse.

Structure
REQ-030 A shared package servo_pkg SHALL hold CICLOS_BASE, CICLOS_PASSO, CICLOS_TIMEOUT, CICLOS_MAX_ALTO defaults and the FSM state encodings, shared with controle_servo_3.
REQ-031 Sub-module detector_borda SHALL contain the synchronizer plus rise/fall pulse generation; all else stays in decodificador_servo_3.

Verification
REQ-032 Reset, then pwm high 50_000 cycles per 20 ms frame -> posicao=000, one valido pulse per frame, erro=0.
REQ-033 Widths 71_874 then 71_875 cycles -> posicao=011 then 100; widths 96_874 -> 111, 96_875 -> erro=1, posicao stays 111.
REQ-034 Width 40_000 cycles after a valid 62_500 -> erro=1, posicao stays 010, no valido; next 56_250 -> posicao=001, erro=0.
REQ-035 pwm held high 200_000 cycles -> erro=1 at count 150_000, db_estado=00 until pwm low, then normal decoding resumes.
REQ-036 pwm held low 1_250_000 cycles -> sem_sinal=1; next valid pulse -> sem_sinal=0 together with valido.
REQ-037 Reset pulse at cycle 30_000 of an 81_250-cycle pulse -> no valido for that pulse; following full pulse -> posicao=101 with 4-edge latency.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared servo timing defaults and FSM state encodings.
// Used by the servo PWM decoder and its controller counterpart.
package servo_pkg;

    localparam int unsigned CICLOS_BASE     = 50_000;
    localparam int unsigned CICLOS_PASSO    = 6_250;
    localparam int unsigned CICLOS_TIMEOUT  = 1_250_000;
    localparam int unsigned CICLOS_MAX_ALTO = 150_000;

    localparam int unsigned LARGURA_W = 18;
    localparam int unsigned PERIODO_W = 21;

    typedef enum logic [1:0] {
        ESPERA_BAIXO  = 2'b00,
        ESPERA_SUBIDA = 2'b01,
        MEDE_ALTO     = 2'b10,
        DECODIFICA    = 2'b11
    } estado_t;

    // Boundary between position j-1 and j, half a step below the nominal width.
    function automatic logic [31:0] limiar(
        input int unsigned base,
        input int unsigned passo,
        input int unsigned j
    );
        return base + j * passo - passo / 2;
    endfunction

endpackage

// File: rtl/detector_borda.sv
// Two-flop synchronizer for the PWM line plus rise/fall pulses.
// Edges are suppressed until the pipeline holds real samples after reset.
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic pwm,
    output logic nivel,
    output logic subida,
    output logic descida,
    output logic pronto
);

    logic       sync1_q;
    logic       sync2_q;
    logic       ant_q;
    logic [2:0] vld_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            ant_q   <= 1'b0;
            vld_q   <= 3'b000;
        end else begin
            sync1_q <= pwm;
            sync2_q <= sync1_q;
            ant_q   <= sync2_q;
            vld_q   <= {vld_q[1:0], 1'b1};
        end
    end

    assign pronto  = vld_q[2];
    assign nivel   = sync2_q;
    assign subida  = pronto & sync2_q & ~ant_q;
    assign descida = pronto & ~sync2_q & ant_q;

endmodule

// File: rtl/decodificador_servo_3.sv
// Servo PWM decoder: measures the high width of each pulse and maps it
// to a 3-bit position, flagging out-of-range, stuck-high and lost signal.
module decodificador_servo_3 #(
    parameter int unsigned CICLOS_BASE     = servo_pkg::CICLOS_BASE,
    parameter int unsigned CICLOS_PASSO    = servo_pkg::CICLOS_PASSO,
    parameter int unsigned CICLOS_TIMEOUT  = servo_pkg::CICLOS_TIMEOUT,
    parameter int unsigned CICLOS_MAX_ALTO = servo_pkg::CICLOS_MAX_ALTO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pwm,
    output logic [2:0] posicao,
    output logic       valido,
    output logic       erro,
    output logic       sem_sinal,
    output logic [1:0] db_estado
);

    import servo_pkg::*;

    localparam logic [LARGURA_W-1:0] MAX_ALTO = LARGURA_W'(CICLOS_MAX_ALTO);
    localparam logic [PERIODO_W-1:0] TIMEOUT  = PERIODO_W'(CICLOS_TIMEOUT);
    localparam logic [31:0] T_MIN = limiar(CICLOS_BASE, CICLOS_PASSO, 0);
    localparam logic [31:0] T_MAX = limiar(CICLOS_BASE, CICLOS_PASSO, 8);

    logic nivel;
    logic subida;
    logic descida;
    logic pronto;

    detector_borda u_borda (
        .clock   (clock),
        .reset   (reset),
        .pwm     (pwm),
        .nivel   (nivel),
        .subida  (subida),
        .descida (descida),
        .pronto  (pronto)
    );

    estado_t              estado_q, estado_d;
    logic [LARGURA_W-1:0] largura_q, largura_d;
    logic [PERIODO_W-1:0] periodo_q, periodo_d;
    logic [2:0]           posicao_q, posicao_d;
    logic                 valido_q, valido_d;
    logic                 erro_q, erro_d;
    logic                 sem_q, sem_d;

    logic [31:0] largura_ext;
    logic        em_faixa;
    logic [2:0]  pos_calc;

    // Position is the number of thresholds crossed; no division needed.
    always_comb begin
        largura_ext = {{(32 - LARGURA_W){1'b0}}, largura_q};
        em_faixa    = (largura_ext >= T_MIN) && (largura_ext < T_MAX);
        pos_calc    = 3'd0;
        for (int unsigned j = 1; j < 8; j++) begin
            if (largura_ext >= limiar(CICLOS_BASE, CICLOS_PASSO, j)) begin
                pos_calc = pos_calc + 3'd1;
            end
        end
    end

    always_comb begin
        estado_d  = estado_q;
        largura_d = largura_q;
        periodo_d = periodo_q;
        posicao_d = posicao_q;
        valido_d  = 1'b0;
        erro_d    = erro_q;
        sem_d     = sem_q;

        if (subida) begin
            periodo_d = '0;
        end else begin
            if (periodo_q < TIMEOUT) begin
                periodo_d = periodo_q + 1'b1;
            end
            if (periodo_q >= TIMEOUT) begin
                sem_d = 1'b1;
            end
        end

        unique case (estado_q)
            ESPERA_BAIXO: begin
                if (pronto && !nivel) begin
                    estado_d = ESPERA_SUBIDA;
                end
            end
            ESPERA_SUBIDA: begin
                if (subida) begin
                    estado_d  = MEDE_ALTO;
                    largura_d = LARGURA_W'(1);
                end
            end
            MEDE_ALTO: begin
                if (descida) begin
                    estado_d = DECODIFICA;
                end else if (largura_q >= MAX_ALTO) begin
                    erro_d   = 1'b1;
                    estado_d = ESPERA_BAIXO;
                end else if (nivel) begin
                    largura_d = largura_q + 1'b1;
                end
            end
            DECODIFICA: begin
                estado_d = ESPERA_SUBIDA;
                if (em_faixa) begin
                    posicao_d = pos_calc;
                    valido_d  = 1'b1;
                    erro_d    = 1'b0;
                    sem_d     = 1'b0;
                end else begin
                    erro_d = 1'b1;
                end
            end
            default: estado_d = ESPERA_BAIXO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= ESPERA_BAIXO;
            largura_q <= '0;
            periodo_q <= '0;
            posicao_q <= 3'd0;
            valido_q  <= 1'b0;
            erro_q    <= 1'b0;
            sem_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            largura_q <= largura_d;
            periodo_q <= periodo_d;
            posicao_q <= posicao_d;
            valido_q  <= valido_d;
            erro_q    <= erro_d;
            sem_q     <= sem_d;
        end
    end

    assign posicao   = posicao_q;
    assign valido    = valido_q;
    assign erro      = erro_q;
    assign sem_sinal = sem_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_decodificador_servo_3.sv
// Directed and randomized frames against an arithmetic model of the decoder.
// Timing parameters are scaled down so the run stays short.
module tb_decodificador_servo_3;

    localparam int BASE     = 400;
    localparam int PASSO    = 50;
    localparam int TIMEOUT  = 2000;
    localparam int MAX_ALTO = 1200;
    localparam int T_MIN    = BASE - PASSO / 2;
    localparam int T_MAX    = BASE + 8 * PASSO - PASSO / 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pwm = 1'b0;
    logic [2:0] posicao;
    logic       valido;
    logic       erro;
    logic       sem_sinal;
    logic [1:0] db_estado;

    int ntests = 0;
    int nfail = 0;
    int nvalid = 0;

    int exp_pos = 0;
    int exp_erro = 0;
    int exp_sem = 0;

    decodificador_servo_3 #(
        .CICLOS_BASE     (BASE),
        .CICLOS_PASSO    (PASSO),
        .CICLOS_TIMEOUT  (TIMEOUT),
        .CICLOS_MAX_ALTO (MAX_ALTO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .pwm       (pwm),
        .posicao   (posicao),
        .valido    (valido),
        .erro      (erro),
        .sem_sinal (sem_sinal),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (valido === 1'b1) nvalid++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic estado_saidas(input string tag);
        chk({tag, ".posicao"}, 32'(posicao), 32'(exp_pos));
        chk({tag, ".erro"}, 32'(erro), 32'(exp_erro));
        chk({tag, ".sem_sinal"}, 32'(sem_sinal), 32'(exp_sem));
    endtask

    // One pulse of 'alto' cycles followed by about 'baixo' low cycles.
    task automatic quadro(input int alto, input int baixo);
        int   nv0;
        int   lat;
        int   exp_nv;
        logic sem_v;
        string tag;
        tag = $sformatf("w%0d", alto);
        nv0 = nvalid;
        lat = 0;
        sem_v = 1'bx;
        pwm = 1'b1;
        repeat (alto) @(negedge clock);
        pwm = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock);
            #1;
            if (valido === 1'b1 && lat == 0) begin
                lat = k;
                sem_v = sem_sinal;
            end
        end
        repeat (baixo - 8) @(negedge clock);
        exp_nv = 0;
        if (alto >= MAX_ALTO) begin
            exp_erro = 1;
        end else if (alto >= T_MIN && alto < T_MAX) begin
            exp_pos = (alto - T_MIN) / PASSO;
            exp_erro = 0;
            exp_sem = 0;
            exp_nv = 1;
        end else begin
            exp_erro = 1;
        end
        chk({tag, ".nvalido"}, 32'(nvalid - nv0), 32'(exp_nv));
        if (exp_nv == 1) begin
            chk({tag, ".latencia"}, 32'(lat), 32'd4);
            chk({tag, ".sem_no_valido"}, 32'(sem_v), 32'd0);
        end
        estado_saidas(tag);
    endtask

    initial begin
        int nv0;
        int a;
        int b;

        repeat (3) @(negedge clock);
        chk("rst.posicao", 32'(posicao), 32'd0);
        chk("rst.valido", 32'(valido), 32'd0);
        chk("rst.erro", 32'(erro), 32'd0);
        chk("rst.sem_sinal", 32'(sem_sinal), 32'd0);
        chk("rst.db_estado", 32'(db_estado), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clock);

        quadro(400, 300);
        quadro(400, 300);
        quadro(400, 300);
        quadro(574, 300);
        quadro(575, 300);
        quadro(774, 300);
        quadro(775, 300);
        quadro(500, 300);
        quadro(320, 300);
        quadro(450, 300);
        quadro(374, 300);
        quadro(375, 300);

        // Stuck-high line
        nv0 = nvalid;
        pwm = 1'b1;
        repeat (1300) @(negedge clock);
        exp_erro = 1;
        chk("preso.erro", 32'(erro), 32'd1);
        chk("preso.db_estado", 32'(db_estado), 32'd0);
        repeat (200) @(negedge clock);
        chk("preso.db_estado_fim", 32'(db_estado), 32'd0);
        pwm = 1'b0;
        repeat (300) @(negedge clock);
        chk("preso.nvalido", 32'(nvalid - nv0), 32'd0);
        estado_saidas("preso");
        quadro(600, 300);

        // Loss of signal
        repeat (2100) @(negedge clock);
        exp_sem = 1;
        chk("timeout.sem_sinal", 32'(sem_sinal), 32'd1);
        quadro(700, 300);

        // Reset in the middle of a pulse
        nv0 = nvalid;
        pwm = 1'b1;
        repeat (300) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_pos = 0;
        exp_erro = 0;
        exp_sem = 0;
        repeat (349) @(negedge clock);
        pwm = 1'b0;
        repeat (200) @(negedge clock);
        chk("rstmeio.nvalido", 32'(nvalid - nv0), 32'd0);
        estado_saidas("rstmeio");
        quadro(650, 300);

        for (int i = 0; i < 12; i++) begin
            a = int'($urandom_range(300, 850));
            b = int'($urandom_range(100, 400));
            quadro(a, b);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
